// File: rtl/addsub_seq_arbiter.sv
// Nibble-serial WIDTH-bit adder/subtractor shared by two requesters.
// Round-robin grant in IDLE, one 4-bit slice per RUN cycle, result held in DONE.
module addsub_seq_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_sub,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_sub,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_ovf,
    output logic             res_id
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             sub_q, sub_d, id_q, id_d, carry_q, carry_d;
    logic             last_q, last_d;
    logic             res_valid_q, res_valid_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             grant0, grant1;
    logic [3:0]       a_nib, b_nib, low_sum;
    logic [4:0]       nib_sum;
    int               k;

    // last_q is the requester served most recently; the other one wins a tie
    assign grant0 = !rst && (state_q == IDLE) && req0_valid && (!req1_valid || last_q);
    assign grant1 = !rst && (state_q == IDLE) && req1_valid && (!req0_valid || !last_q);

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign res_valid  = res_valid_q;
    assign res_sum    = sum_q;
    assign res_cout   = cout_q;
    assign res_ovf    = ovf_q;
    assign res_id     = id_q;

    always_comb begin
        k       = int'(cnt_q);
        a_nib   = a_q[4*k +: 4];
        b_nib   = b_q[4*k +: 4] ^ {4{sub_q}};
        nib_sum = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0, carry_q};
        // bit 3 of low_sum is the carry into the nibble MSB, needed for overflow
        low_sum = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b0, carry_q};

        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sub_d       = sub_q;
        id_d        = id_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        last_d      = last_q;
        res_valid_d = res_valid_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;

        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    a_d     = grant1 ? req1_a : req0_a;
                    b_d     = grant1 ? req1_b : req0_b;
                    sub_d   = grant1 ? req1_sub : req0_sub;
                    id_d    = grant1;
                    carry_d = grant1 ? req1_sub : req0_sub;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[4*k +: 4] = nib_sum[3:0];
                carry_d         = nib_sum[4];
                if (cnt_q == CW'(NIB - 1)) begin
                    cout_d      = nib_sum[4];
                    ovf_d       = low_sum[3] ^ nib_sum[4];
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    last_d      = id_q;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            id_q        <= 1'b0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= '0;
            last_q      <= 1'b1;
            res_valid_q <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sub_q       <= sub_d;
            id_q        <= id_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            last_q      <= last_d;
            res_valid_q <= res_valid_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
        end
    end
endmodule

// File: tb/tb_addsub_seq_arbiter.sv
// Directed bench for addsub_seq_arbiter: vector table for single ops,
// plus round-robin, result back-pressure and mid-operation reset sequences.
module tb_addsub_seq_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_sub;
    logic [15:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_sub;
    logic [15:0] req1_a, req1_b;
    logic        res_valid, res_ready, res_cout, res_ovf, res_id;
    logic [15:0] res_sum;

    int n_pass = 0;
    int n_total = 0;

    addsub_seq_arbiter #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_cout(res_cout), .res_ovf(res_ovf), .res_id(res_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0_valid = 0; req1_valid = 0; res_ready = 0;
        rst = 1;
        tick(); tick();
        rst = 0;
    endtask

    task automatic run_op(input vec_t v);
        int n, lat, rdy;
        logic rq;
        if (v.id) begin
            req1_a = v.a; req1_b = v.b; req1_sub = v.sub; req1_valid = 1;
        end else begin
            req0_a = v.a; req0_b = v.b; req0_sub = v.sub; req0_valid = 1;
        end
        #1;
        n = 0;
        rq = v.id ? req1_ready : req0_ready;
        while (!rq && n < 20) begin
            tick(); n++;
            rq = v.id ? req1_ready : req0_ready;
        end
        chk("accept_seen", rq, 1);
        chk("other_ready_low", v.id ? req0_ready : req1_ready, 0);
        rdy = 1;
        tick(); lat = 1;
        // scramble operands after acceptance; the op in flight must not see them
        req0_a = 16'hDEAD; req0_b = 16'hBEEF; req1_a = 16'hDEAD; req1_b = 16'hBEEF;
        while (!res_valid && lat < 20) begin
            if (v.id ? req1_ready : req0_ready) rdy++;
            tick(); lat++;
        end
        chk("latency", lat, 5);
        chk("ready_pulses", rdy, 1);
        chk("ready_in_done", v.id ? req1_ready : req0_ready, 0);
        chk("sum", res_sum, v.sum);
        chk("cout", res_cout, v.cout);
        chk("ovf", res_ovf, v.ovf);
        chk("id", res_id, v.id);
        req0_valid = 0; req1_valid = 0;
        res_ready = 1;
        tick();
        chk("valid_drop", res_valid, 0);
        res_ready = 0;
    endtask

    initial begin
        int n_acc, n_res, cyc, last_t, n;
        logic seen;

        vecs[0] = '{1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0};

        req0_a = 0; req0_b = 0; req0_sub = 0;
        req1_a = 0; req1_b = 0; req1_sub = 0;
        do_reset();
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_sum", res_sum, 0);
        chk("rst_res_cout", res_cout, 0);
        chk("rst_res_ovf", res_ovf, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);

        foreach (vecs[i]) run_op(vecs[i]);

        // both requesters always pending: grants alternate starting at req0
        do_reset();
        req0_a = 16'd1;  req0_b = 16'd2; req0_sub = 0;
        req1_a = 16'd10; req1_b = 16'd3; req1_sub = 1;
        req0_valid = 1; req1_valid = 1; res_ready = 1;
        #1;
        n_acc = 0; n_res = 0; cyc = 0; last_t = 0;
        while (n_acc < 4 && cyc < 60) begin
            chk("rr_one_ready", req0_ready & req1_ready, 0);
            if (req0_ready || req1_ready) begin
                chk("rr_grant_id", req1_ready, n_acc % 2);
                if (n_acc > 0) chk("rr_spacing", cyc - last_t, 6);
                last_t = cyc;
                n_acc++;
            end
            if (res_valid) begin
                chk("rr_res_id", res_id, n_res % 2);
                chk("rr_res_sum", res_sum, (n_res % 2) ? 16'd7 : 16'd3);
                n_res++;
            end
            tick(); cyc++;
        end
        chk("rr_accepts", n_acc, 4);

        // result held under back-pressure while req0 waits
        do_reset();
        req0_a = 16'h0100; req0_b = 16'h0200; req0_sub = 0; req0_valid = 1;
        #1;
        n = 0;
        while (!req0_ready && n < 20) begin tick(); n++; end
        tick();
        n = 0;
        while (!res_valid && n < 20) begin tick(); n++; end
        chk("bp_valid_seen", res_valid, 1);
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid_hold", res_valid, 1);
            chk("bp_sum_hold", res_sum, 16'h0300);
            chk("bp_id_hold", res_id, 0);
            chk("bp_cout_hold", res_cout, 0);
            chk("bp_ready0_low", req0_ready, 0);
            tick();
        end
        res_ready = 1;
        tick();
        chk("bp_valid_cleared", res_valid, 0);
        chk("bp_reaccept", req0_ready, 1);
        res_ready = 0;
        tick();
        req0_valid = 0;

        // reset in the middle of RUN discards the op
        do_reset();
        req0_a = 16'h1111; req0_b = 16'h2222; req0_sub = 0; req0_valid = 1;
        #1;
        chk("abort_accept", req0_ready, 1);
        tick();
        req0_valid = 0;
        tick();
        rst = 1;
        tick();
        rst = 0;
        chk("abort_valid", res_valid, 0);
        chk("abort_sum", res_sum, 0);
        chk("abort_cout", res_cout, 0);
        chk("abort_ovf", res_ovf, 0);
        chk("abort_id", res_id, 0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (res_valid) seen = 1;
            tick();
        end
        chk("abort_no_result", seen, 0);
        req0_valid = 1; req1_valid = 1;
        #1;
        chk("abort_tie_req0", req0_ready, 1);
        chk("abort_tie_req1", req1_ready, 0);
        req0_valid = 0; req1_valid = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
